// File: rtl/sample_mode_sched.sv
// -----------------------------------------------------------------------------
// sample_mode_sched
//
// Round-robin scheduler for the shared SHAKE-to-sample converter. Four
// requesters compete for the converter:
//   0 = sampleU, 1 = sampleA, 2 = sampleU sign, 3 = cpoly.
// For the granted job the block drives the converter mode, gates the SHAKE
// data strobe into it, and counts produced coefficients up to the job target.
// It then waits a fixed drain period, flushes the converter and reports done.
//
// Optional watchdog: define SCHED_TIMEOUT_EN to abort a RUN job that sees no
// counted strobe for TIMEOUT_CYC cycles. The abort sets the sticky err_o and
// still pulses done. Without the macro err_o is tied to 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[3:0]        level request per mode, held until its done bit
//   u_i[5:0]        u parameter, latched at grant
//   shake_valid_i   SHAKE output word valid
//   a_flag_i        converter sampleA output strobe
//   u_flag_i        converter sampleU output strobe
//   c_flag_i        converter Chash address strobe
//   grant[3:0]      one-hot grant, high for the whole job
//   done[3:0]       one-cycle completion pulse per mode
//   busy            high in every state except IDLE
//   mode_o[1:0]     converter Din_mod
//   u_o[5:0]        latched u to converter inp_u
//   shake_en_o      squeeze enable to the SHAKE core
//   din_flag_o      shake_valid_i gated by shake_en_o
//   sample_rst_o    one-cycle converter flush pulse
//   coef_cnt_o[8:0] coefficients counted in the current job
//   err_o           watchdog abort sticky flag
// -----------------------------------------------------------------------------
module sample_mode_sched #(
  parameter int N_COEF    = 256,
  parameter int N_CPOLY   = 16,
  parameter int DRAIN_CYC = 8
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [5:0] u_i,
  input  logic       shake_valid_i,
  input  logic       a_flag_i,
  input  logic       u_flag_i,
  input  logic       c_flag_i,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       busy,
  output logic [1:0] mode_o,
  output logic [5:0] u_o,
  output logic       shake_en_o,
  output logic       din_flag_o,
  output logic       sample_rst_o,
  output logic [8:0] coef_cnt_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int            DW         = $clog2(DRAIN_CYC) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [9:0]    TGT_COEF   = 10'(N_COEF);
  localparam logic [9:0]    TGT_CPOLY  = 10'(N_CPOLY);

  state_t        state, state_n;
  logic [3:0]    grant_n;
  logic [1:0]    mode_n;
  logic [5:0]    u_n;
  logic          shake_en_n;
  logic [8:0]    coef_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic [1:0]    rr, rr_n;
  logic          dropped, dropped_n;   // job ended by request withdrawal

  logic [1:0]    pick_idx;
  logic [1:0]    inc;
  logic [9:0]    cnt_sum;
  logic [9:0]    target;
  logic          reached;
  logic          req_held;
  logic          timeout;

  // First requester at or after the round-robin pointer, wrapping. Scanning
  // downward lets the lowest offset win.
  always_comb begin
    pick_idx = rr;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(rr + 2'(k))]) pick_idx = 2'(rr + 2'(k));
    end
  end

  // Only the strobe belonging to the granted mode counts; sampleU yields two
  // coefficients per strobe.
  always_comb begin
    unique case (mode_o)
      2'd0:    inc = u_flag_i ? 2'd2 : 2'd0;
      2'd1:    inc = {1'b0, a_flag_i};
      2'd2:    inc = {1'b0, u_flag_i};
      default: inc = {1'b0, c_flag_i};
    endcase
  end

  assign cnt_sum  = {1'b0, coef_cnt_o} + {8'd0, inc};
  assign target   = (mode_o == 2'd3) ? TGT_CPOLY : TGT_COEF;
  assign reached  = (cnt_sum >= target);
  assign req_held = |(req & grant);

`ifdef SCHED_TIMEOUT_EN
  localparam int            IW        = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  logic [IW-1:0] idle_cnt;
  logic          err_q;

  assign timeout = (state == S_RUN) && req_held && (inc == 2'd0) &&
                   (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_RUN || inc != 2'd0) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + IW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    // NOTE: every next value defaults to its current value (or zero) before
    // the case, so no path leaves a signal unassigned and no latch is inferred.
    state_n    = state;
    grant_n    = grant;
    mode_n     = mode_o;
    u_n        = u_o;
    shake_en_n = shake_en_o;
    coef_n     = coef_cnt_o;
    drain_n    = '0;
    rr_n       = rr;
    dropped_n  = dropped;

    unique case (state)
      S_IDLE: begin
        if (|req) begin
          grant_n   = 4'b0001 << pick_idx;
          mode_n    = pick_idx;
          u_n       = u_i;
          coef_n    = '0;
          dropped_n = 1'b0;
          state_n   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!req_held) begin
          dropped_n = 1'b1;
          state_n   = S_DRAIN;
        end else begin
          shake_en_n = 1'b1;
          state_n    = S_RUN;
        end
      end
      S_RUN: begin
        if (!req_held) begin
          shake_en_n = 1'b0;
          dropped_n  = 1'b1;
          state_n    = S_DRAIN;
        end else if (reached) begin
          coef_n     = target[8:0];
          shake_en_n = 1'b0;
          state_n    = S_DRAIN;
        end else if (timeout) begin
          shake_en_n = 1'b0;
          state_n    = S_DRAIN;
        end else begin
          coef_n = cnt_sum[8:0];
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
        else                         drain_n = drain_cnt + DW'(1);
      end
      S_DONE: begin
        grant_n = '0;
        rr_n    = mode_o + 2'd1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      mode_o     <= '0;
      u_o        <= '0;
      shake_en_o <= 1'b0;
      coef_cnt_o <= '0;
      drain_cnt  <= '0;
      rr         <= '0;
      dropped    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_n;
      grant      <= grant_n;
      mode_o     <= mode_n;
      u_o        <= u_n;
      shake_en_o <= shake_en_n;
      coef_cnt_o <= coef_n;
      drain_cnt  <= drain_n;
      rr         <= rr_n;
      dropped    <= dropped_n;
    end
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE && !dropped) ? grant : 4'b0000;
  assign sample_rst_o = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign din_flag_o   = shake_valid_i & shake_en_o;

endmodule

// File: doc/sample_mode_sched.md
Name: sample_mode_sched

Overview:
- Scheduler for the shared SHAKE-to-sample converter.
- Arbitrates round-robin between four sampling requesters:
  - 0 = sampleU
  - 1 = sampleA
  - 2 = sampleU sign
  - 3 = cpoly
- For the granted job it drives the converter mode, gates the SHAKE data strobe into the converter, and counts produced coefficients up to a target. It then drains, flushes the converter and reports done to the requester.

Parameters:
- N_COEF, 256, coefficients per job for modes 0/1/2
- N_CPOLY, 16, Chash address strobes per job for mode 3
- DRAIN_CYC, 8, cycles waited after target reached before flush (covers converter pipeline)
- TIMEOUT_CYC, 1024, watchdog limit; used only with SCHED_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  level request per mode; held until matching done bit
- u_i  in  6  u parameter from requesters; latched at grant
- shake_valid_i  in  1  SHAKE output word valid
- a_flag_i  in  1  converter sampleA output strobe
- u_flag_i  in  1  converter sampleU output strobe
- c_flag_i  in  1  converter Chash address strobe
- grant  out  4  one-hot, high for whole job
- done  out  4  one-cycle completion pulse, per mode
- busy  out  1  high in any state except IDLE
- mode_o  out  2  converter Din_mod
- u_o  out  6  latched u to converter inp_u
- shake_en_o  out  1  squeeze enable to SHAKE core
- din_flag_o  out  1  shake_valid_i & shake_en_o, combinational
- sample_rst_o  out  1  one-cycle converter flush pulse
- coef_cnt_o  out  9  coefficients counted in current job
- err_o  out  1  watchdog abort sticky flag; constant 0 without the optional feature

Behaviour:

Reset (async on rst_n low):
- All outputs and registers 0; state IDLE; rr pointer 0.

FSM:
- IDLE:
  - If any req, pick first set bit scanning from rr pointer upward with wrap. Register grant, mode_o = index, u_o = u_i, coef_cnt_o = 0. Go to SETUP.
  - Latency req -> grant: 1 cycle.
- SETUP: 1 cycle so mode_o settles at the converter. Go to RUN with shake_en_o = 1.
- RUN:
  - Count increment, taken only from the flag belonging to the granted mode; other flags ignored:
    - mode 0: +2 per u_flag_i (two coefficients per strobe)
    - mode 1: +1 per a_flag_i
    - mode 2: +1 per u_flag_i
    - mode 3: +1 per c_flag_i
  - When the incremented count >= target (N_CPOLY for mode 3, else N_COEF): shake_en_o = 0 on the same edge, go to DRAIN. Count saturates at target.
- DRAIN:
  - Counter reloaded to 0 and counts DRAIN_CYC cycles; all flags ignored.
  - At the final cycle, sample_rst_o = 1 for exactly 1 cycle. Go to DONE.
- DONE:
  - done[g] pulses 1 cycle, grant cleared, rr pointer = g+1 mod 4. Go to IDLE.
  - A new grant can therefore issue no earlier than 1 cycle after done.

Boundary cases:
- Request dropped mid-job: req[g] deasserts in SETUP/RUN -> shake_en_o = 0, go to DRAIN, flush normally, no done pulse, pointer advances.
- Request arriving during a job: ignored until IDLE.
- shake_valid_i while shake_en_o is 0: not forwarded.
- Grant and mode are never changed outside IDLE.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - In RUN, an idle counter resets on every counted flag and increments otherwise.
  - Reaching TIMEOUT_CYC: err_o set (sticky until rst_n), job aborted via the DRAIN/flush path, done[g] still pulses so the requester releases.
- Undefined: no watchdog logic; err_o tied 0.

Test Plan:
- req=0010, a_flag_i every 3 cycles -> grant=0010 one cycle later, mode_o=1. shake_en_o drops on the edge the 256th flag counts. sample_rst_o pulses 8 cycles later, then done[1]. coef_cnt_o=256 at DRAIN entry.
- Mode 0 with 129 u_flag_i strobes -> count reaches 256 at the 128th strobe. The 129th strobe falls in DRAIN and is ignored, count stays 256.
- req=1111 from reset -> grant order 0,1,2,3,0. Each job completes with the correct mode_o, and N_CPOLY=16 c_flag_i strobes end job 3.
- req[2] dropped after 10 strobes -> shake_en_o=0 next edge, flush pulse, no done, next grant goes to index 3.
- rst_n low mid-RUN -> all outputs 0 immediately; after release, IDLE with pointer 0.
- With SCHED_TIMEOUT_EN and TIMEOUT_CYC=64, no flags after grant -> err_o=1 at cycle 64 of RUN, flush, done pulse. Without the macro, the job waits indefinitely and err_o stays 0.
